pc_sequencer: RTL and testbench

Owns the fetch-stage program counter of the 5-stage MIPS pipeline and sequences every PC update. It chooses the next fetch address from these sources: sequential PC+4, branch target, jump target or exception vector. It honours hazard-unit stalls, holds redirects that arrive during a stall, and drives the IF/ID flush and fetch-valid qualifiers.

---
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: sequential fetch, branch/jump redirects, stall hold with a pending
// redirect slot, and exception vectoring. Define ALIGN_CHECK_EN to trap misaligned targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        exc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        if_valid_o,
  output logic        flush_o,
  output logic        addr_err_o
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] PEND = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic        misaligned;
  logic        flush;
  logic        addr_err;

  assign redirect   = branch_taken_i | jump_i;
  assign raw_target = branch_taken_i ? branch_target_i : jump_target_i;

`ifdef ALIGN_CHECK_EN
  assign misaligned = |raw_target[1:0];
  assign target     = raw_target;
`else
  assign misaligned = 1'b0;
  assign target     = raw_target & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    flush    = 1'b0;
    addr_err = 1'b0;
    if (exc_i) begin
      pc_d    = EXC_VECTOR;
      pend_d  = 32'h0;
      flush   = 1'b1;
      state_d = RUN;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN, HOLD: begin
          if (redirect && misaligned) begin
            // Bad target traps exactly like an exception request.
            addr_err = 1'b1;
            pc_d     = EXC_VECTOR;
            pend_d   = 32'h0;
            flush    = 1'b1;
            state_d  = RUN;
          end else if (redirect) begin
            flush = 1'b1;
            if (stall_i) begin
              pend_d  = target;
              state_d = PEND;
            end else begin
              pc_d    = target;
              state_d = RUN;
            end
          end else if (stall_i) begin
            state_d = HOLD;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = RUN;
          end
        end
        PEND: begin
          // Younger redirects are dropped; the latched one is older in program order.
          if (!stall_i) begin
            pc_d    = pend_q;
            pend_d  = 32'h0;
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;
  assign flush_o    = flush;
  assign if_valid_o = (state_q != BOOT) && !flush;
  assign addr_err_o = addr_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, async-reset corner case, and random stimulus
// checked against a behavioural model.
module tb_pc_sequencer;

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam logic [31:0] EXC = 32'h0000_0080;
  localparam logic [31:0] PC_AFTER_MIS = ALIGN ? 32'h0000_0080 : 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i, branch_taken_i, jump_i, exc_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic [31:0] pc_o, pc_plus4_o;
  logic        if_valid_o, flush_o, addr_err_o;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .exc_i           (exc_i),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .if_valid_o      (if_valid_o),
    .flush_o         (flush_o),
    .addr_err_o      (addr_err_o)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        exc;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;

  // Behavioural model: just "still booting", the PC, and an optional pending target.
  logic        m_boot;
  logic [31:0] m_pc;
  logic        m_pv;
  logic [31:0] m_ptgt;

  function automatic vec_t v(input logic stall, input logic br, input logic [31:0] bt,
                             input logic jmp, input logic [31:0] jt, input logic exc,
                             input logic [31:0] pc, input logic fl, input logic val,
                             input logic err);
    vec_t r;
    r.stall = stall; r.br = br; r.bt = bt; r.jmp = jmp; r.jt = jt; r.exc = exc;
    r.exp_pc = pc; r.exp_flush = fl; r.exp_valid = val; r.exp_err = err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
  endtask

  task automatic set_in(input logic stall, input logic br, input logic [31:0] bt,
                        input logic jmp, input logic [31:0] jt, input logic exc);
    stall_i = stall; branch_taken_i = br; branch_target_i = bt;
    jump_i = jmp; jump_target_i = jt; exc_i = exc;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] pc, input logic fl,
                            input logic val, input logic err);
    check({tag, " pc"}, pc_o, pc);
    check({tag, " pc_plus4"}, pc_plus4_o, pc + 32'd4);
    check({tag, " flush"}, {31'b0, flush_o}, {31'b0, fl});
    check({tag, " if_valid"}, {31'b0, if_valid_o}, {31'b0, val});
    check({tag, " addr_err"}, {31'b0, addr_err_o}, {31'b0, err});
  endtask

  task automatic model_step(input logic stall, input logic br, input logic [31:0] bt,
                            input logic jmp, input logic [31:0] jt, input logic exc,
                            output logic [31:0] e_pc, output logic e_fl,
                            output logic e_val, output logic e_err);
    logic [31:0] tgt;
    e_pc = m_pc; e_fl = 1'b0; e_err = 1'b0;
    tgt = br ? bt : jt;
    if (exc) begin
      e_fl = 1'b1; m_pc = EXC; m_pv = 1'b0;
    end else if (m_boot) begin
      e_fl = 1'b0;
    end else if (m_pv) begin
      if (!stall) begin m_pc = m_ptgt; m_pv = 1'b0; end
    end else if (br || jmp) begin
      e_fl = 1'b1;
      if (ALIGN && tgt[1:0] != 2'b00) begin
        e_err = 1'b1; m_pc = EXC;
      end else if (stall) begin
        m_pv = 1'b1; m_ptgt = {tgt[31:2], 2'b00};
      end else begin
        m_pc = {tgt[31:2], 2'b00};
      end
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
    e_val = !m_boot && !e_fl;
    m_boot = 1'b0;
  endtask

  initial begin
    logic [31:0] e_pc;
    logic        e_fl, e_val, e_err;
    logic        s, b, j, x;
    logic [31:0] bt, jt;

    set_in(0, 0, 0, 0, 0, 0);

    // Directed sequence, one record per cycle starting with the BOOT cycle.
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h4, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h8, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'hC, 0, 1, 0));
    vecs.push_back(v(0, 1, 32'h100, 0, 0, 0, 32'h10, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h100, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 32'h20, 0, 32'h104, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 32'h20, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 1, 32'h400, 0, 32'h20, 1, 0, 0));
    vecs.push_back(v(1, 1, 32'h990, 0, 0, 0, 32'h20, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h20, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h400, 0, 1, 0));
    vecs.push_back(v(1, 1, 32'h500, 0, 0, 1, 32'h404, 1, 0, 0));
    vecs.push_back(v(1, 1, 32'h600, 0, 0, 0, 32'h80, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 32'h80, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h80, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 32'h202, 0, 32'h84, 1, 0, ALIGN));
    vecs.push_back(v(0, 0, 0, 1, 32'hFFFF_FFFC, 0, PC_AFTER_MIS, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h4, 0, 1, 0));

    repeat (2) @(negedge clk);
    check_outs("reset", 32'h0, 0, 0, 0);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      set_in(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt, vecs[i].exc);
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_flush,
                 vecs[i].exp_valid, vecs[i].exp_err);
      @(negedge clk);
    end

    // Async reset while a redirect is pending must drop the pending target.
    set_in(1, 0, 0, 1, 32'h444, 0);
    @(negedge clk);
    set_in(1, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_outs("async_rst", 32'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    #2 check_outs("post_rst boot", 32'h0, 0, 0, 0);
    @(negedge clk);
    #2 check_outs("post_rst first", 32'h0, 0, 1, 0);
    @(negedge clk);
    #2 check_outs("post_rst second", 32'h4, 0, 1, 0);
    @(negedge clk);

    // Randomized run against the model.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_boot = 1'b1; m_pc = 32'h0; m_pv = 1'b0; m_ptgt = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 5) == 0);
      j = ($urandom_range(0, 5) == 0);
      x = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0: bt = $urandom();
        1: bt = 32'hFFFF_FFF8;
        default: bt = $urandom() & 32'h0000_FFFC;
      endcase
      case ($urandom_range(0, 9))
        0: jt = $urandom();
        1: jt = 32'hFFFF_FFFC;
        default: jt = $urandom() & 32'h0000_FFFC;
      endcase
      if (m_boot) begin b = 1'b0; j = 1'b0; end
      set_in(s, b, bt, j, jt, x);
      model_step(s, b, bt, j, jt, x, e_pc, e_fl, e_val, e_err);
      #2 check_outs($sformatf("rand%0d", n), e_pc, e_fl, e_val, e_err);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
